// File: rtl/matrix_result_writer.sv
// Ping-pong buffered writer that drains per-core result batches into a result memory,
// one lane per cycle, skipping lanes past the matrix edge and counting accepted words.
module matrix_result_writer #(
  parameter int CORE_COUNT = 4,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 10
) (
  input  logic                         CLOCK_25,
  input  logic                         rst,
  input  logic                         i_start,
  input  logic                         i_capture,
  input  logic [CORE_COUNT*DATA_W-1:0] i_results,
  input  logic [4:0]                   i_row,
  input  logic [4:0]                   i_core_column,
  input  logic [7:0]                   i_size_column,
  input  logic [7:0]                   i_size_row,
  input  logic                         i_mem_ready,
  output logic                         o_mem_we,
  output logic [ADDR_W-1:0]            o_mem_addr,
  output logic [DATA_W-1:0]            o_mem_data,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_overflow,
  output logic [15:0]                  o_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam int NL_W = $clog2(CORE_COUNT + 1);

  logic [1:0]                   r_state;
  logic [1:0]                   r_slotValid;
  logic [CORE_COUNT*DATA_W-1:0] r_slotData [2];
  logic [4:0]                   r_slotRow [2];
  logic [4:0]                   r_slotCol [2];
  logic                         r_head;
  logic [NL_W-1:0]              r_nextLane;
  logic                         r_memWe;
  logic [ADDR_W-1:0]            r_memAddr;
  logic [DATA_W-1:0]            r_memData;
  logic [15:0]                  r_count;
  logic                         r_overflow;

  logic                  w_other;
  logic [CORE_COUNT-1:0] w_laneOk [2];
  logic                  w_headHit;
  logic [NL_W-1:0]       w_headLane;
  logic                  w_otherHit;
  logic [NL_W-1:0]       w_otherLane;
  logic                  w_accept;
  logic                  w_outFree;
  logic                  w_drainEn;
  logic                  w_doIssue;
  logic                  w_issueSlot;
  logic [NL_W-1:0]       w_issueLane;
  logic                  w_freeHead;
  logic                  w_headNext;
  logic                  w_headNextOther;
  logic                  w_headFinal;
  logic [NL_W-1:0]       w_nextLaneNext;
  logic [1:0]            w_freeing;
  logic [1:0]            w_slotFree;
  logic                  w_capOk;
  logic [1:0]            w_load;
  logic                  w_drop;
  logic [1:0]            w_validNext;
  logic [15:0]           w_countNext;
  logic [15:0]           w_total;
  logic [1:0]            w_stateNext;
  logic [DATA_W-1:0]     w_issueData;
  logic [15:0]           w_issueAddr16;

  assign w_other     = ~r_head;
  assign w_accept    = r_memWe & i_mem_ready;
  assign w_outFree   = ~r_memWe | i_mem_ready;
  assign w_drainEn   = w_outFree & (r_state != S_DONE) & ~i_start;
  assign w_countNext = r_count + {15'd0, w_accept};
  assign w_total     = 16'(i_size_row) * 16'(i_size_column);

  // A lane is written only while its column lies inside the matrix.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      w_laneOk[s] = '0;
      for (int k = 0; k < CORE_COUNT; k++) begin
        w_laneOk[s][k] = (16'(r_slotCol[s]) + 16'(k)) < 16'(i_size_column);
      end
    end
  end

  always_comb begin
    w_headHit   = 1'b0;
    w_headLane  = '0;
    w_otherHit  = 1'b0;
    w_otherLane = '0;
    for (int k = CORE_COUNT - 1; k >= 0; k--) begin
      if (w_laneOk[r_head][k] && (NL_W'(k) >= r_nextLane)) begin
        w_headHit  = 1'b1;
        w_headLane = NL_W'(k);
      end
      if (w_laneOk[w_other][k]) begin
        w_otherHit  = 1'b1;
        w_otherLane = NL_W'(k);
      end
    end
  end

  // Look ahead into the other slot when the head finishes so slot changes cost no bubble.
  always_comb begin
    w_doIssue      = 1'b0;
    w_issueSlot    = r_head;
    w_issueLane    = '0;
    w_freeHead     = 1'b0;
    w_headNext     = r_head;
    w_nextLaneNext = r_nextLane;
    if (w_drainEn && r_slotValid[r_head]) begin
      if (w_headHit) begin
        w_doIssue      = 1'b1;
        w_issueLane    = w_headLane;
        w_nextLaneNext = w_headLane + NL_W'(1);
      end else begin
        w_freeHead     = 1'b1;
        w_headNext     = w_other;
        w_nextLaneNext = '0;
        if (r_slotValid[w_other] && w_otherHit) begin
          w_doIssue      = 1'b1;
          w_issueSlot    = w_other;
          w_issueLane    = w_otherLane;
          w_nextLaneNext = w_otherLane + NL_W'(1);
        end
      end
    end
  end

  assign w_freeing[0] = w_freeHead & ~r_head;
  assign w_freeing[1] = w_freeHead & r_head;
  assign w_slotFree   = ~r_slotValid | w_freeing;
  assign w_capOk      = i_capture & ~i_start & (r_state != S_DONE);

  always_comb begin
    w_load = 2'b00;
    if (w_capOk) begin
      if (w_slotFree[0]) begin
        w_load[0] = 1'b1;
      end else if (w_slotFree[1]) begin
        w_load[1] = 1'b1;
      end
    end
  end

  assign w_drop          = w_capOk & ~(|w_slotFree);
  assign w_validNext     = (r_slotValid & ~w_freeing) | w_load;
  assign w_headNextOther = ~w_headNext;

  always_comb begin
    w_headFinal = w_headNext;
    if (!w_validNext[w_headNext] && w_validNext[w_headNextOther]) begin
      w_headFinal = w_headNextOther;
    end
  end

  always_comb begin
    w_issueData = '0;
    for (int k = 0; k < CORE_COUNT; k++) begin
      if (w_issueLane == NL_W'(k)) begin
        w_issueData = r_slotData[w_issueSlot][k*DATA_W +: DATA_W];
      end
    end
  end

  assign w_issueAddr16 = 16'(r_slotRow[w_issueSlot]) * 16'(i_size_column)
                       + 16'(r_slotCol[w_issueSlot]) + 16'(w_issueLane);

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE:  if (|r_slotValid) w_stateNext = S_WRITE;
      S_WRITE: if (~|w_validNext) w_stateNext = S_IDLE;
      default: w_stateNext = r_state;
    endcase
    if ((r_state != S_DONE) && (w_countNext == w_total)) begin
      w_stateNext = S_DONE;
    end
  end

  // Start clears the job but leaves the last address/data visible on the idle port.
  always_ff @(posedge CLOCK_25 or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_slotValid   <= 2'b00;
      r_slotData[0] <= '0;
      r_slotData[1] <= '0;
      r_slotRow[0]  <= '0;
      r_slotRow[1]  <= '0;
      r_slotCol[0]  <= '0;
      r_slotCol[1]  <= '0;
      r_head        <= 1'b0;
      r_nextLane    <= '0;
      r_memWe       <= 1'b0;
      r_memAddr     <= '0;
      r_memData     <= '0;
      r_count       <= '0;
      r_overflow    <= 1'b0;
    end else if (i_start) begin
      r_state     <= S_IDLE;
      r_slotValid <= 2'b00;
      r_head      <= 1'b0;
      r_nextLane  <= '0;
      r_memWe     <= 1'b0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_slotValid <= w_validNext;
      r_head      <= w_headFinal;
      r_nextLane  <= w_nextLaneNext;
      r_count     <= w_countNext;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      for (int s = 0; s < 2; s++) begin
        if (w_load[s]) begin
          r_slotData[s] <= i_results;
          r_slotRow[s]  <= i_row;
          r_slotCol[s]  <= i_core_column;
        end
      end
      if (w_doIssue && (w_stateNext != S_DONE)) begin
        r_memWe   <= 1'b1;
        r_memAddr <= ADDR_W'(w_issueAddr16);
        r_memData <= w_issueData;
      end else if (w_outFree) begin
        r_memWe <= 1'b0;
      end
    end
  end

  assign o_mem_we   = r_memWe;
  assign o_mem_addr = r_memAddr;
  assign o_mem_data = r_memData;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
  assign o_done     = (r_state == S_DONE);
  assign o_busy     = (r_state == S_WRITE) | (|r_slotValid);

endmodule
